// File: rtl/dt_param.sv
// dt_param: two-pass (forward/backward raster) distance transform of a binary image,
// using the external result RAM as the only frame store.
module dt_param #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int WORD_W = 16,
    parameter int DIST_W = 8,
    localparam int SA_W  = $clog2(IMG_W * IMG_H / WORD_W),
    localparam int RA_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              metric,
    output logic              busy,
    output logic              done,
    output logic              sti_rd,
    output logic [SA_W-1:0]   sti_addr,
    input  logic [WORD_W-1:0] sti_di,
    output logic              res_wr,
    output logic              res_rd,
    output logic [RA_W-1:0]   res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di
);
    localparam int XW = $clog2(IMG_W);
    localparam int WB = $clog2(WORD_W);
    localparam logic [RA_W-1:0] ROW = RA_W'(IMG_W);
    localparam logic [DIST_W-1:0] DMAX = '1;
    localparam logic [DIST_W-1:0] ONE = DIST_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, FWD, BWD, FIN} state_t;
    typedef enum logic [1:0] {PH_C, PH_X, PH_L, PH_W} phase_t;

    state_t state_q, state_d;
    phase_t ph_q, ph_d;
    logic [RA_W-1:0] pix_q, pix_d, la;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic metric_q, metric_d;
    logic [DIST_W-1:0] ctr_q, ctr_d, pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
    logic pass, bwd, chess, row0, col0, coln, need_x, need_l, inner, fg, last, wend;
    logic [DIST_W-1:0] m, inc, result;

    function automatic logic [DIST_W-1:0] dmin(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
        return a < b ? a : b;
    endfunction

    // Each pass walks a logical raster; the backward pass mirrors it by inverting the address,
    // so its E/SE/S/SW neighbours become the same W/NW/N/NE window as the forward pass.
    always_comb begin
        pass   = state_q == FWD || state_q == BWD;
        bwd    = state_q == BWD;
        chess  = !metric_q;
        row0   = pix_q < ROW;
        col0   = pix_q[XW-1:0] == '0;
        coln   = &pix_q[XW-1:0];
        need_x = chess && !row0 && col0;
        need_l = !row0 && !(chess && coln);
        inner  = need_l && !col0;
        last   = &pix_q;
        wend   = ((pix_q + 1'b1) & RA_W'(WORD_W - 1)) == '0;
        fg     = ctr_q != '0;
        m      = chess ? dmin(dmin(pa_q, pb_q), dmin(pc_q, res_di)) : dmin(pa_q, res_di);
        inc    = m == DMAX ? DMAX : m + ONE;
        result = !inner ? ONE : bwd ? dmin(ctr_q, inc) : inc;
        la     = ph_q == PH_X ? pix_q - ROW : ph_q == PH_L ? pix_q - ROW + RA_W'(chess) : pix_q;
        busy     = state_q != IDLE;
        done     = state_q == FIN;
        sti_rd   = state_q == LOAD && ph_q == PH_C;
        res_rd   = pass && (ph_q == PH_C || ph_q == PH_X || (ph_q == PH_L && need_l));
        res_wr   = ph_q == PH_W && (state_q == LOAD || (pass && fg));
        sti_addr = sti_rd ? SA_W'(pix_q >> WB) : '0;
        res_addr = (res_rd || res_wr) ? (bwd ? ~la : la) : '0;
        res_do   = !res_wr ? '0 : state_q == LOAD ? DIST_W'(sh_q[WORD_W-1]) : result;
        state_d  = state_q;
        ph_d     = ph_q;
        pix_d    = pix_q;
        sh_d     = sh_q;
        metric_d = metric_q;
        ctr_d    = ctr_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        pc_d     = pc_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = LOAD;
                ph_d     = PH_C;
                pix_d    = '0;
                metric_d = metric;
            end
            LOAD: case (ph_q)
                PH_C: ph_d = PH_X;
                PH_X: begin
                    sh_d = sti_di;
                    ph_d = PH_W;
                end
                default: begin
                    sh_d    = sh_q << 1;
                    pix_d   = pix_q + 1'b1;
                    ph_d    = wend ? PH_C : PH_W;
                    state_d = last ? FWD : LOAD;
                end
            endcase
            FWD, BWD: case (ph_q)
                PH_C: ph_d = need_x ? PH_X : PH_L;
                PH_X: begin
                    ctr_d = res_di;
                    ph_d  = PH_L;
                end
                PH_L: begin
                    ctr_d = need_x ? ctr_q : res_di;
                    pc_d  = need_x ? res_di : pc_q;
                    ph_d  = PH_W;
                end
                default: begin
                    pa_d  = fg ? result : '0;
                    pb_d  = pc_q;
                    pc_d  = res_di;
                    pix_d = pix_q + 1'b1;
                    ph_d  = PH_C;
                    state_d = !last ? state_q : bwd ? FIN : BWD;
                end
            endcase
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ph_q     <= PH_C;
            pix_q    <= '0;
            sh_q     <= '0;
            metric_q <= 1'b0;
            ctr_q    <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            pix_q    <= pix_d;
            sh_q     <= sh_d;
            metric_q <= metric_d;
            ctr_q    <= ctr_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            pc_q     <= pc_d;
        end
    end
endmodule

// File: doc/dt_param.md
DT_PARAM -- requirements
Module: dt_param

Interface
REQ-001 Parameters (name, default, meaning): IMG_W, 128, image width in pixels (power of 2, >= WORD_W); IMG_H, 128, image height in pixels (power of 2); WORD_W, 16, pixels per sti word (power of 2); DIST_W, 8, distance width in bits.
REQ-002 Derived widths: SA_W = log2(IMG_W*IMG_H/WORD_W); RA_W = log2(IMG_W*IMG_H).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a frame.
REQ-006 metric  in  1  0 = chessboard (8-neighbour), 1 = city-block (4-neighbour); sampled when start is accepted.
REQ-007 busy  out  1  high while a frame is in progress.
REQ-008 done  out  1  one-cycle pulse at frame completion.
REQ-009 sti_rd  out  1  binary-image ROM read strobe.
REQ-010 sti_addr  out  SA_W  ROM word address.
REQ-011 sti_di  in  WORD_W  ROM data, valid the cycle after sti_rd; MSB = leftmost pixel.
REQ-012 res_wr  out  1  result RAM write strobe.
REQ-013 res_rd  out  1  result RAM read strobe.
REQ-014 res_addr  out  RA_W  RAM address = row*IMG_W + col.
REQ-015 res_do  out  DIST_W  RAM write data.
REQ-016 res_di  in  DIST_W  RAM read data, valid the cycle after res_rd.

Function
REQ-017 The result RAM SHALL be the only frame store; no internal frame buffer.
REQ-018 FSM states: IDLE, LOAD, FWD, BWD, FIN.
REQ-019 IDLE -> LOAD on start; start SHALL be ignored in any other state.
REQ-020 busy SHALL be high from the cycle after start is accepted until the cycle done is asserted, inclusive.
REQ-021 LOAD: words 0..IMG_W*IMG_H/WORD_W-1 read in ascending order; pixel bit b of word k written to res_addr k*WORD_W + (WORD_W-1-b) as value 0 or 1, one write per cycle.
REQ-022 FWD: raster order (row 0..IMG_H-1, col 0..IMG_W-1); background pixel (0) skipped without write; foreground pixel gets min(W, NW, N, NE)+1 (chessboard) or min(W, N)+1 (city-block).
REQ-023 BWD: reverse raster order; foreground pixel gets min(centre, min(E, SE, S, SW)+1) (chessboard) or min(centre, min(E, S)+1) (city-block); background skipped.
REQ-024 Out-of-image neighbours SHALL be treated as 0 and SHALL NOT be read from RAM.
REQ-025 The +1 SHALL saturate at 2^DIST_W-1; comparisons unsigned, DIST_W bits.
REQ-026 res_rd and res_wr SHALL never be high in the same cycle; res_addr and res_do stable in the cycle of the strobe.
REQ-027 sti_rd and res_rd SHALL be single-cycle strobes; data captured exactly one cycle later.
REQ-028 FIN: done high one cycle after the last BWD write (or after the last pixel visit if it was skipped), then IDLE.
REQ-029 Per-pixel cycle count is implementation-defined; total frame time SHALL NOT exceed 8*IMG_W*IMG_H + IMG_W*IMG_H/WORD_W + 16 cycles.

Reset
REQ-030 On reset low: state IDLE; busy, done, sti_rd, res_wr, res_rd = 0; sti_addr, res_addr, res_do = 0; takes effect immediately, including mid-frame.
REQ-031 After reset mid-frame, RAM contents are undefined; the next start SHALL process a full frame correctly.

Verification
REQ-032 Default params, all-zero image, metric 0 -> all 16384 RAM locations 0, done pulses once, busy low after.
REQ-033 Default params, single 1 at (64,64), either metric -> RAM(64*128+64)=1, all others 0.
REQ-034 IMG_W=IMG_H=8, WORD_W=8, all ones except (3,3)=0 -> metric 0: (4,4)=1, (7,7)=1, (0,0)=1; metric 1: (4,4)=2, (5,5)=3.
REQ-035 IMG_W=IMG_H=8, WORD_W=8, DIST_W=2, all ones, metric 0 -> (3,3)=3 (saturated from 4), (1,1)=2, (0,0)=1.
REQ-036 Reset asserted mid-FWD -> all outputs 0 same cycle; start pulsed during busy ignored (single done); fresh start after reset gives REQ-033 result.
REQ-037 Protocol checker on all runs: no res_rd/res_wr overlap, no out-of-range address, no read of out-of-image neighbour.
